// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory port bundle for mem_access_unit.
// master = pipeline plus memory environment, slave = the access unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_signed, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_addr, mem_wdata, mem_size, mem_we, mem_re
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_addr, mem_wdata, mem_size, mem_we, mem_re
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and the asynchronous data memory.
// Misaligned loads become two word reads plus a merge; misaligned stores become byte writes.
module mem_access_unit #(
  parameter logic [15:0] MEM_BASE = 16'h1000
) (
  input logic              clock,
  input logic              reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, WRB, RSP, ERR} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, w0_q, w1_q, held_addr, held_wdata;
  logic [1:0]  size_q, byte_cnt;
  logic        we_q, signed_q, misaligned_q;

  logic        idle_ready, accept, req_error, req_misaligned;
  logic [15:0] last_hi;
  logic [31:0] word_addr, raw, load_data;
  logic [7:0]  wdata_byte;

  logic        rsp_valid, rsp_error, mem_we, mem_re;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;

  assign idle_ready = (state == IDLE) && !reset;
  assign accept     = bus.req_valid && idle_ready;

  // The size code equals N-1, so addr+size is the last addressed byte (wraps mod 2^32).
  assign last_hi   = 16'((bus.req_addr + {30'd0, bus.req_size}) >> 16);
  assign req_error = (bus.req_size == 2'd2) || (bus.req_addr[31:16] != MEM_BASE) ||
                     (last_hi != MEM_BASE);

  always_comb begin
    req_misaligned = 1'b0;
    case (bus.req_size)
      2'd1:    req_misaligned = (bus.req_addr[1:0] == 2'd3);
      2'd3:    req_misaligned = (bus.req_addr[1:0] != 2'd0);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign word_addr  = {addr_q[31:2], 2'b00};
  assign raw        = 32'({w1_q, w0_q} >> {addr_q[1:0], 3'b000});
  assign wdata_byte = 8'(wdata_q >> {byte_cnt, 3'b000});

  always_comb begin
    load_data = raw;
    case (size_q)
      2'd0:    load_data = {{24{signed_q & raw[7]}}, raw[7:0]};
      2'd1:    load_data = {{16{signed_q & raw[15]}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outside the memory states the address/data buses replay their last driven value.
  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    rsp_error  = 1'b0;
    rsp_rdata  = '0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_size   = 2'd0;
    mem_addr   = held_addr;
    mem_wdata  = held_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error)           state_next = ERR;
          else if (!bus.req_we)    state_next = RD0;
          else if (req_misaligned) state_next = WRB;
          else                     state_next = WR;
        end
      end
      RD0: begin
        mem_re     = 1'b1;
        mem_size   = 2'd3;
        mem_addr   = word_addr;
        state_next = misaligned_q ? RD1 : RSP;
      end
      RD1: begin
        mem_re     = 1'b1;
        mem_size   = 2'd3;
        mem_addr   = word_addr + 32'd4;
        state_next = RSP;
      end
      WR: begin
        mem_we     = 1'b1;
        mem_size   = size_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        state_next = RSP;
      end
      WRB: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q + {30'd0, byte_cnt};
        mem_wdata = {24'd0, wdata_byte};
        if (byte_cnt == size_q) state_next = RSP;
      end
      RSP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = we_q ? 32'd0 : load_data;
        state_next = IDLE;
      end
      ERR: begin
        rsp_valid  = 1'b1;
        rsp_error  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      misaligned_q <= 1'b0;
      w0_q         <= '0;
      w1_q         <= '0;
      byte_cnt     <= '0;
      held_addr    <= '0;
      held_wdata   <= '0;
    end else begin
      held_addr  <= mem_addr;
      held_wdata <= mem_wdata;
      if (accept) begin
        addr_q       <= bus.req_addr;
        wdata_q      <= bus.req_wdata;
        size_q       <= bus.req_size;
        we_q         <= bus.req_we;
        signed_q     <= bus.req_signed;
        misaligned_q <= req_misaligned;
        w1_q         <= '0;
        byte_cnt     <= '0;
      end
      if (state == RD0) w0_q <= bus.mem_rdata;
      if (state == RD1) w1_q <= bus.mem_rdata;
      if (state == WRB) byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign bus.req_ready = idle_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_error = rsp_error;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.mem_size  = mem_size;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level reference memory predicts every response,
// a negedge monitor compares data, error, latency and memory-cycle counts.
module tb_mem_access_unit;
  logic clock;
  logic reset;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BASE(16'h1000)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_re;
    int          n_we;
    int          acc_cyc;
    int          id;
  } exp_t;

  exp_t     sb[$];
  int       checks, fails, cyc, re_cnt, we_cnt, txn_id;
  bit [7:0] mem     [0:4095];
  bit [7:0] ref_mem [0:4095];
  logic [11:0] ra;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // Data memory: combinational read of the word at mem_addr, writes on posedge.
  assign ra            = bus.mem_addr[11:0];
  assign bus.mem_rdata = {mem[ra + 12'd3], mem[ra + 12'd2], mem[ra + 12'd1], mem[ra]};

  always @(posedge clock) begin
    if (bus.mem_we) begin
      mem[ra] <= bus.mem_wdata[7:0];
      if (bus.mem_size != 2'd0) mem[ra + 12'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_size == 2'd3) begin
        mem[ra + 12'd2] <= bus.mem_wdata[23:16];
        mem[ra + 12'd3] <= bus.mem_wdata[31:24];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: an access touches bytes addr..addr+N-1; it costs extra cycles only when those
  // bytes span two memory words.
  function automatic exp_t modelAccess(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [1:0] size,
                                       input logic sgn);
    exp_t        e;
    int          n;
    logic [31:0] a, val;
    bit          crosses;
    e.rdata = '0; e.err = 1'b0; e.n_re = 0; e.n_we = 0; e.lat = 1; e.acc_cyc = 0; e.id = 0;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd2) e.err = 1'b1;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      if (a[31:16] != 16'h1000) e.err = 1'b1;
    end
    if (e.err) return e;
    crosses = (int'(addr[1:0]) + n) > 4;
    if (we) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        ref_mem[a[11:0]] = wdata[8*k +: 8];
      end
      e.n_we = crosses ? n : 1;
      e.lat  = crosses ? n + 1 : 2;
    end else begin
      val = '0;
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        val[8*k +: 8] = ref_mem[a[11:0]];
      end
      if (sgn && n < 4 && val[8*n-1])
        for (int k = n; k < 4; k++) val[8*k +: 8] = 8'hFF;
      e.rdata = val;
      e.n_re  = crosses ? 2 : 1;
      e.lat   = crosses ? 3 : 2;
    end
    return e;
  endfunction

  // Monitor: counts memory cycles per transaction and checks each completion pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      re_cnt = 0;
      we_cnt = 0;
    end else begin
      if (bus.mem_re) re_cnt++;
      if (bus.mem_we) we_cnt++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected 0");
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("txn%0d rdata", e.id), bus.rsp_rdata, e.rdata);
          checkOutput($sformatf("txn%0d error", e.id), 32'(bus.rsp_error), 32'(e.err));
          checkOutput($sformatf("txn%0d latency", e.id), 32'(cyc - e.acc_cyc), 32'(e.lat));
          checkOutput($sformatf("txn%0d mem_re_cycles", e.id), 32'(re_cnt), 32'(e.n_re));
          checkOutput($sformatf("txn%0d mem_we_cycles", e.id), 32'(we_cnt), 32'(e.n_we));
        end
        re_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  // Called at a negedge; waits for req_ready, issues one request and records its prediction.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic sgn);
    exp_t e;
    int   waitc;
    waitc = 0;
    while (!bus.req_ready && waitc < 100) begin
      @(negedge clock);
      waitc++;
    end
    if (!bus.req_ready) begin
      checks++;
      fails++;
      $display("[TB] FAIL req_ready_timeout: got req_ready=0, expected 1 within 100 cycles");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_size   = size;
    bus.req_signed = sgn;
    e         = modelAccess(we, addr, wdata, size, sgn);
    e.acc_cyc = cyc;
    e.id      = txn_id++;
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic drainScoreboard();
    int waitc;
    waitc = 0;
    while (sb.size() != 0 && waitc < 200) begin
      @(negedge clock);
      waitc++;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d outstanding responses, expected 0", sb.size());
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    int          r;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset mem_we_re", 32'({bus.mem_we, bus.mem_re}), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle req_ready", 32'(bus.req_ready), 32'd1);

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 32'h10000004, 32'hDEADBEEF, 2'd3, 1'b0);
    applyStimulus(1'b0, 32'h10000004, 32'h0,        2'd3, 1'b0);
    applyStimulus(1'b1, 32'h10000000, 32'h8077F0AA, 2'd3, 1'b0);
    applyStimulus(1'b0, 32'h10000001, 32'h0,        2'd0, 1'b1);
    applyStimulus(1'b0, 32'h10000002, 32'h0,        2'd1, 1'b0);
    applyStimulus(1'b1, 32'h10000000, 32'h44332211, 2'd3, 1'b0);
    applyStimulus(1'b1, 32'h10000004, 32'h88776655, 2'd3, 1'b0);
    applyStimulus(1'b0, 32'h10000003, 32'h0,        2'd3, 1'b0);
    applyStimulus(1'b1, 32'h10000006, 32'hA1B2C3D4, 2'd3, 1'b0);
    applyStimulus(1'b0, 32'h10000006, 32'h0,        2'd3, 1'b0);
    applyStimulus(1'b0, 32'h20000000, 32'h0,        2'd3, 1'b0);
    applyStimulus(1'b0, 32'h10000000, 32'h0,        2'd2, 1'b0);
    applyStimulus(1'b1, 32'h10000009, 32'h0000BEEF, 2'd1, 1'b0);
    applyStimulus(1'b0, 32'h10000009, 32'h0,        2'd1, 1'b1);
    applyStimulus(1'b1, 32'h1000000B, 32'h00001234, 2'd1, 1'b0);
    applyStimulus(1'b0, 32'h1000000B, 32'h0,        2'd1, 1'b1);
    applyStimulus(1'b1, 32'h1000FFFF, 32'h0000005A, 2'd0, 1'b0);
    applyStimulus(1'b0, 32'h1000FFFF, 32'h0,        2'd0, 1'b1);
    applyStimulus(1'b0, 32'h1000FFFF, 32'h0,        2'd1, 1'b0);
    applyStimulus(1'b1, 32'h1000FFFE, 32'h11223344, 2'd3, 1'b0);
    applyStimulus(1'b0, 32'hFFFFFFFE, 32'h0,        2'd3, 1'b0);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      addr = {16'h2000 + 16'($urandom_range(0, 255)), 16'($urandom)};
      else if (r == 1) addr = 32'h1000FFFC + 32'($urandom_range(0, 3));
      else             addr = 32'h10000000 + 32'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd3 : 2'd2;
      applyStimulus(1'($urandom_range(0, 1)), addr, 32'($urandom), size,
                    1'($urandom_range(0, 1)));
    end
    drainScoreboard();

    $display("[TB] reset during misaligned store");
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h10000101;
    bus.req_wdata  = 32'hA1B2C3D4;
    bus.req_size   = 2'd3;
    bus.req_signed = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midreset mem_we_re", 32'({bus.mem_we, bus.mem_re}), 32'd0);
    checkOutput("midreset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("midreset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("midreset mem_wdata", bus.mem_wdata, 32'd0);
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("postreset req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clock);
    checkOutput("postreset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    applyStimulus(1'b0, 32'h10000010, 32'h0, 2'd3, 1'b0);
    drainScoreboard();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
